mult8_seq_ctrl: RTL and testbench

MULT8_SEQ_CTRL -- requirements
Module: mult8_seq_ctrl

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult4_core.sv | 13 +
 rtl/mult8_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_mult8_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the 8x8 sequential multiplier.
// The shift table maps each 4x4 partial product onto the 16-bit result.
package mult_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned HALF_W = 4;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    WAITPP = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] SHIFT_TBL [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

endpackage

// File: rtl/mult4_core.sv
// Combinational 4x4 unsigned multiplier, 8-bit product.
// Stateless; the controller time-shares it over four steps.
import mult_pkg::*;

module mult4_core (
  input  logic [HALF_W-1:0]   A,
  input  logic [HALF_W-1:0]   B,
  output logic [2*HALF_W-1:0] P
);

  assign P = {{HALF_W{1'b0}}, A} * {{HALF_W{1'b0}}, B};

endmodule

// File: rtl/mult8_seq_ctrl.sv
// 8x8 unsigned multiplier built from one shared 4x4 core.
// Four steps per operation, optional register on the partial product.
import mult_pkg::*;

module mult8_seq_ctrl #(
  parameter int PP_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] P,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic [PROD_W-1:0]   acc_q, acc_d;

  logic [HALF_W-1:0]   m_a, m_b;
  logic [2*HALF_W-1:0] m_p;
  logic [2*HALF_W-1:0] acc_in;
  logic                acc_step;

  // Operands are forced to zero outside MUL to keep the core quiet.
  always_comb begin
    m_a = '0;
    m_b = '0;
    if (state_q == MUL) begin
      m_a = cnt_q[1] ? a_q[7:4] : a_q[3:0];
      m_b = cnt_q[0] ? b_q[7:4] : b_q[3:0];
    end
  end

  mult4_core u_core (
    .A (m_a),
    .B (m_b),
    .P (m_p)
  );

  if (PP_REG != 0) begin : g_pp
    logic [2*HALF_W-1:0] pp_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        pp_q <= '0;
      end else if (state_q == MUL) begin
        pp_q <= m_p;
      end
    end

    assign acc_in   = pp_q;
    assign acc_step = (state_q == WAITPP);
  end else begin : g_nopp
    assign acc_in   = m_p;
    assign acc_step = (state_q == MUL);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;

    if (acc_step) begin
      acc_d = acc_q + (PROD_W'(acc_in) << SHIFT_TBL[cnt_q]);
      cnt_d = cnt_q + 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (PP_REG != 0) begin
          state_d = WAITPP;
        end else if (cnt_q == 2'd3) begin
          state_d = DONE;
        end
      end
      WAITPP: begin
        state_d = (cnt_q == 2'd3) ? DONE : MUL;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign P         = acc_q;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Scoreboard bench: both PP_REG variants side by side, directed then random.
// Expected products come from plain A*B pushed at every accept.
module tb_mult8_seq_ctrl;

  localparam int NRAND = 2000;

  logic clk = 1'b0;
  logic rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  A         [2];
  logic [7:0]  B         [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] P         [2];
  logic        busy      [2];

  logic ordir [2];
  logic rmode  = 1'b0;
  logic mon_en = 1'b0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    logic [15:0] p;
    int          c;
  } exp_t;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gm
    localparam int LAT = 4 * (1 + g);
    exp_t q[$];

    mult8_seq_ctrl #(.PP_REG(g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .A         (A[g]),
      .B         (B[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .P         (P[g]),
      .busy      (busy[g])
    );

    initial begin
      exp_t        e;
      logic        pv;
      logic        pwait;
      logic [15:0] pp;
      pv = 1'b0;
      pwait = 1'b0;
      pp = '0;
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (rst) begin
            q.delete();
            pv = 1'b0;
            pwait = 1'b0;
          end else begin
            chk("ready_vs_busy", 32'(in_ready[g]), 32'(!busy[g]));
            if (pwait) begin
              chk("hold_valid", 32'(out_valid[g]), 32'd1);
              chk("hold_p", 32'(P[g]), 32'(pp));
            end
            if (out_valid[g] && !pv) begin
              chk("result_pending", 32'(q.size() > 0), 32'd1);
              if (q.size() > 0)
                chk("latency", 32'(cyc - q[0].c), 32'(LAT));
            end
            if (out_valid[g] && out_ready[g]) begin
              chk("no_duplicate", 32'(q.size() > 0), 32'd1);
              if (q.size() > 0) begin
                e = q.pop_front();
                chk("product", 32'(P[g]), 32'(e.p));
              end
            end
            if (in_valid[g] && in_ready[g]) begin
              e.p = 16'(A[g]) * 16'(B[g]);
              e.c = cyc + 1;
              q.push_back(e);
            end
            pwait = out_valid[g] && !out_ready[g];
            pp    = P[g];
            pv    = out_valid[g];
          end
        end
      end
    end
  end

  initial begin
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int g = 0; g < 2; g++)
        out_ready[g] = rmode ? ($urandom_range(0, 3) != 0) : ordir[g];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [7:0] a,
                      input logic [7:0] b);
    int n;
    n = 0;
    while (!in_ready[g] && n < 200) begin
      step();
      n++;
    end
    if (!in_ready[g]) begin
      chk("send_timeout", 32'(in_ready[g]), 32'd1);
    end else begin
      in_valid[g] = 1'b1;
      A[g] = a;
      B[g] = b;
      step();
      in_valid[g] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (!in_ready[g] && n < 200) begin
      step();
      n++;
    end
    chk("idle_reached", 32'(in_ready[g]), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0;
      A[g] = '0;
      B[g] = '0;
      ordir[g] = 1'b1;
    end
    @(posedge clk);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int g = 0; g < 2; g++) begin
      chk("rst_in_ready", 32'(in_ready[g]), 32'd1);
      chk("rst_busy", 32'(busy[g]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[g]), 32'd0);
      chk("rst_p", 32'(P[g]), 32'd0);
    end

    send(0, 8'hFF, 8'hFF);
    wait_idle(0);
    send(1, 8'h12, 8'h34);
    wait_idle(1);

    ordir[0] = 1'b0;
    send(0, 8'h80, 8'h02);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      step();
      n++;
    end
    chk("stall_valid", 32'(out_valid[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready[0]), 32'd0);
      chk("stall_p", 32'(P[0]), 32'h0100);
      step();
    end
    ordir[0] = 1'b1;
    chk("pulse_in_ready", 32'(in_ready[0]), 32'd0);
    step();
    chk("after_pulse_ready", 32'(in_ready[0]), 32'd1);

    send(0, 8'h00, 8'hA5);
    in_valid[0] = 1'b1;
    A[0] = 8'h55;
    B[0] = 8'h55;
    n = 0;
    while (!in_ready[0] && n < 20) begin
      step();
      n++;
    end
    chk("ignored_while_busy", 32'(n), 32'd5);
    step();
    in_valid[0] = 1'b0;
    wait_idle(0);

    send(0, 8'hC3, 8'h3C);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort_p", 32'(P[0]), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid[0]) seen++;
      step();
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    send(0, 8'h0F, 8'h0F);
    wait_idle(0);

    rmode = 1'b1;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          repeat ($urandom_range(0, 2)) step();
          send(0, ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom),
                  8'($urandom));
        end
      end
      begin
        for (int j = 0; j < NRAND; j++) begin
          repeat ($urandom_range(0, 2)) step();
          send(1, 8'($urandom),
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
        end
      end
    join
    rmode = 1'b0;
    step();
    wait_idle(0);
    wait_idle(1);
    step();
    chk("drain0", 32'(gm[0].q.size()), 32'd0);
    chk("drain1", 32'(gm[1].q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
